// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use interlock, EX redirect flush,
// data-memory wait stalls with a timeout fault, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFault   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   flush_events_q, flush_events_d;

  logic mem_hold;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  assign mem_hold = (state_q == StRun && mem_req && !mem_ack) ||
                    (state_q == StMemWait && !mem_ack) ||
                    (state_q == StFault);

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_memread && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // Priority: memory hold freezes everything, then redirect, then load-use interlock.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (mem_hold) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_req && !mem_ack) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(MEM_TIMEOUT)) begin
          state_d = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
    fault_d = (state_d == StFault);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (id_ex_flush && (flush_events_q != {CNT_W{1'b1}})) begin
      flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      wait_cnt_q     <= '0;
      fault_q        <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      fault_q        <= fault_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign state        = state_q;
  assign fault        = fault_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short memory timeout and narrow counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;

  logic            clk;
  logic            rst;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_req, mem_ack;
  logic            pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic            if_id_flush, id_ex_flush, mem_wb_bubble, fault;
  logic [1:0]      state;
  logic [CntW-1:0] stall_cycles, flush_events;

  int tests = 0;
  int fails = 0;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble),
    .state        (state),
    .fault        (fault),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic set_load_use();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  // Advance one clock, leaving time just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #2;
    rst = 1'b1;
    set_load_use();
    mem_req = 1'b1;
    #1;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", state); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b required 0", fault); end
    tests++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d required 0", stall_cycles); end
    tests++; if (flush_events !== 4'd0) begin fails++; $display("FAIL reset_flush_cnt: got %0d required 0", flush_events); end
    tests++; if ({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble} !== 7'b0) begin
      fails++; $display("FAIL reset_outputs: got %b required 0000000",
        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble});
    end
    step();
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use();
    #1;
    tests++; if ({pc_stall, if_id_stall, id_ex_flush} !== 3'b111) begin
      fails++; $display("FAIL load_use_active: got %b required 111", {pc_stall, if_id_stall, id_ex_flush});
    end
    tests++; if ({id_ex_stall, ex_mem_stall, if_id_flush, mem_wb_bubble} !== 4'b0) begin
      fails++; $display("FAIL load_use_others: got %b required 0000",
        {id_ex_stall, ex_mem_stall, if_id_flush, mem_wb_bubble});
    end
    step();
    clear_inputs();
    #1;
    tests++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL load_use_release: got %b required 0", pc_stall); end
    tests++; if (stall_cycles !== 4'd1) begin fails++; $display("FAIL load_use_stall_cnt: got %0d required 1", stall_cycles); end
    tests++; if (flush_events !== 4'd1) begin fails++; $display("FAIL load_use_flush_cnt: got %0d required 1", flush_events); end
  endtask

  task automatic test_x0_unused();
    apply_reset();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    tests++; if ({pc_stall, id_ex_flush} !== 2'b00) begin
      fails++; $display("FAIL x0_no_hazard: got %b required 00", {pc_stall, id_ex_flush});
    end
    id_use_rs1 = 1'b0; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0;
    #1;
    tests++; if ({pc_stall, id_ex_flush} !== 2'b00) begin
      fails++; $display("FAIL unused_rs2_no_hazard: got %b required 00", {pc_stall, id_ex_flush});
    end
    id_use_rs2 = 1'b1;
    #1;
    tests++; if ({pc_stall, if_id_stall, id_ex_flush} !== 3'b111) begin
      fails++; $display("FAIL rs2_hazard: got %b required 111", {pc_stall, if_id_stall, id_ex_flush});
    end
    ex_memread = 1'b0;
    #1;
    tests++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL non_load_no_hazard: got %b required 0", pc_stall); end
    clear_inputs();
  endtask

  task automatic test_redirect_priority();
    apply_reset();
    set_load_use();
    ex_redirect = 1'b1;
    #1;
    tests++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin
      fails++; $display("FAIL redirect_flush: got %b required 11", {if_id_flush, id_ex_flush});
    end
    tests++; if ({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall} !== 4'b0) begin
      fails++; $display("FAIL redirect_no_stall: got %b required 0000",
        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall});
    end
    step();
    clear_inputs();
    #1;
    tests++; if ({stall_cycles, flush_events} !== {4'd0, 4'd1}) begin
      fails++; $display("FAIL redirect_counts: got stall=%0d flush=%0d required stall=0 flush=1",
        stall_cycles, flush_events);
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_state [3];
    exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1;
    apply_reset();
    mem_req = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (state !== exp_state[i]) begin
        fails++; $display("FAIL mem_wait_state[%0d]: got %0d required %0d", i, state, exp_state[i]);
      end
      tests++; if ({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush}
                   !== 7'b1111100) begin
        fails++; $display("FAIL mem_wait_hold[%0d]: got %b required 1111100", i,
          {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush});
      end
      step();
    end
    mem_ack = 1'b1;
    #1;
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL mem_ack_state: got %0d required 1", state); end
    tests++; if ({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble} !== 5'b0) begin
      fails++; $display("FAIL mem_ack_release: got %b required 00000",
        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble});
    end
    tests++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin
      fails++; $display("FAIL deferred_redirect: got %b required 11", {if_id_flush, id_ex_flush});
    end
    step();
    clear_inputs();
    #1;
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL mem_wait_done_state: got %0d required 0", state); end
    tests++; if ({stall_cycles, flush_events} !== {4'd3, 4'd1}) begin
      fails++; $display("FAIL mem_wait_counts: got stall=%0d flush=%0d required stall=3 flush=1",
        stall_cycles, flush_events);
    end
  endtask

  task automatic test_single_cycle_access();
    apply_reset();
    mem_req = 1'b1; mem_ack = 1'b1;
    #1;
    tests++; if ({pc_stall, mem_wb_bubble} !== 2'b00) begin
      fails++; $display("FAIL single_cycle_no_stall: got %b required 00", {pc_stall, mem_wb_bubble});
    end
    step();
    tests++; if ({state, stall_cycles} !== {2'd0, 4'd0}) begin
      fails++; $display("FAIL single_cycle_state: got state=%0d stall=%0d required state=0 stall=0",
        state, stall_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1'b1;
    repeat (4) step();
    tests++; if ({state, fault} !== {2'd1, 1'b0}) begin
      fails++; $display("FAIL timeout_before: got state=%0d fault=%b required state=1 fault=0", state, fault);
    end
    step();
    tests++; if ({state, fault} !== {2'd2, 1'b1}) begin
      fails++; $display("FAIL timeout_fault: got state=%0d fault=%b required state=2 fault=1", state, fault);
    end
    tests++; if ({pc_stall, ex_mem_stall, mem_wb_bubble} !== 3'b111) begin
      fails++; $display("FAIL fault_hold: got %b required 111", {pc_stall, ex_mem_stall, mem_wb_bubble});
    end
    tests++; if (stall_cycles !== 4'd5) begin fails++; $display("FAIL timeout_stall_cnt: got %0d required 5", stall_cycles); end
    mem_req = 1'b0; mem_ack = 1'b1;
    #1;
    tests++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL late_ack_stall: got %b required 1", pc_stall); end
    step();
    tests++; if ({state, fault} !== {2'd2, 1'b1}) begin
      fails++; $display("FAIL late_ack_state: got state=%0d fault=%b required state=2 fault=1", state, fault);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++; if ({state, fault, stall_cycles, flush_events} !== {2'd0, 1'b0, 4'd0, 4'd0}) begin
      fails++; $display("FAIL fault_reset: got state=%0d fault=%b stall=%0d flush=%0d required all 0",
        state, fault, stall_cycles, flush_events);
    end
    tests++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL fault_reset_stall: got %b required 0", pc_stall); end
    step();
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mem_req = 1'b1;
    repeat (3) step();
    mem_ack = 1'b1;
    step();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL b2b_first_done: got %0d required 0", state); end
    mem_ack = 1'b0;
    repeat (4) step();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL b2b_second_wait: got %0d required 1", state); end
    step();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL b2b_second_fault: got %0d required 2", state); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    set_load_use();
    repeat (14) step();
    tests++; if (stall_cycles !== 4'd14) begin fails++; $display("FAIL sat_14: got %0d required 14", stall_cycles); end
    step();
    tests++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_15: got %0d required 15", stall_cycles); end
    repeat (5) step();
    tests++; if (stall_cycles !== 4'd15) begin fails++; $display("FAIL sat_hold_stall: got %0d required 15", stall_cycles); end
    tests++; if (flush_events !== 4'd15) begin fails++; $display("FAIL sat_hold_flush: got %0d required 15", flush_events); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_redirect_priority();
    test_mem_wait();
    test_single_cycle_access();
    test_timeout();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles MEM_WAIT may persist before FAULT.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_memread  in  1  EX instruction is a load.
REQ-009 ex_redirect  in  1  branch taken or jump resolved in EX; PC redirect this cycle.
REQ-010 mem_req  in  1  MEM stage holds a load/store requiring a data-memory or MMIO response.
REQ-011 mem_ack  in  1  data memory response valid this cycle.
REQ-012 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the PC or named pipeline register.
REQ-013 if_id_flush, id_ex_flush  out  1 each  clear the named pipeline register to a bubble.
REQ-014 mem_wb_bubble  out  1  MEM/WB captures a bubble (RegWrite=0) instead of the MEM result.
REQ-015 state  out  2  FSM state: RUN=0, MEM_WAIT=1, FAULT=2.
REQ-016 fault  out  1  high while in FAULT.
REQ-017 stall_cycles, flush_events  out  CNT_W each  saturating performance counters.

Function
REQ-018 All stall/flush/bubble outputs SHALL be combinational from the current state and inputs (zero-cycle latency).
REQ-019 mem_hold = (state==RUN && mem_req && !mem_ack) || (state==MEM_WAIT && !mem_ack) || state==FAULT.
REQ-020 While mem_hold: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall = 1; mem_wb_bubble = 1; both flushes = 0; all other hazards are ignored.
REQ-021 load_use = ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-022 If !mem_hold and ex_redirect: if_id_flush=1 and id_ex_flush=1; all stalls = 0; load_use is ignored (redirect wins).
REQ-023 If !mem_hold, !ex_redirect and load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1; all other outputs = 0.
REQ-024 Otherwise all stall/flush/bubble outputs = 0.
REQ-025 FSM RUN: mem_req && !mem_ack -> MEM_WAIT, with wait_cnt loaded to 1; otherwise stay in RUN.
REQ-026 FSM MEM_WAIT: mem_ack -> RUN, and stalls release in the ack cycle itself; else if wait_cnt==MEM_TIMEOUT -> FAULT; else wait_cnt increments.
REQ-027 wait_cnt SHALL be an internal counter of width ceil(log2(MEM_TIMEOUT+1)) and SHALL be cleared on entry to RUN.
REQ-028 FSM FAULT: absorbing; only rst exits it; mem_ack is ignored.
REQ-029 mem_ack while in RUN with mem_req=1 is a single-cycle access: no stall, state stays RUN.
REQ-030 ex_redirect asserted during mem_hold SHALL NOT flush; EX is frozen, so the redirect is acted on in the first cycle mem_hold is low.
REQ-031 stall_cycles increments in every cycle where pc_stall=1.
REQ-032 flush_events increments in every cycle where id_ex_flush=1.
REQ-033 Both counters SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-034 Asserting rst SHALL, without waiting for a clock edge, set state=RUN, wait_cnt=0, fault=0, stall_cycles=0, flush_events=0.
REQ-035 During reset all stall/flush/bubble outputs SHALL be 0.
REQ-036 rst asserted mid-MEM_WAIT or in FAULT SHALL abort to RUN; no pending memory or redirect context is retained.

Verification
REQ-037 Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle; stall_cycles=1, flush_events=1.
REQ-038 x0 and unused-operand check: ex_rd=0 with id_rs1=0; then ex_rd=7, id_rs2=7, id_use_rs2=0 -> no stall, no flush in either case.
REQ-039 Redirect plus load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-040 Memory wait: mem_req=1, mem_ack low for 3 cycles then high -> all stalls and mem_wb_bubble high for 3 cycles, low in the ack cycle; state sequence 0,1,1,1 then 0.
REQ-041 Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ack never asserted -> state=2 and fault=1 after 5 cycles; stalls held; late mem_ack has no effect; rst -> state=0, all counters 0.
REQ-042 Counter saturation with CNT_W=4: 20 consecutive load-use cycles -> stall_cycles=15 and holds at 15.
